lcd_cmd_arbiter: RTL and testbench
==================================

Name: lcd_cmd_arbiter

Overview:
- Sequences and shares the single LCD 1602A controller between N client requesters.
- After reset it issues INIT autonomously, then grants the controller round-robin to requesters wanting SEND_DATA or CLEAR.
- Owns the controller's cmd/enable handshake: holds enable through busy, detects completion, and forces the mandatory enable-low gap.
- Watchdogs both handshake phases and flags hangs.

Parameters:
NREQ, 2, number of requesters (2..8).
BUSY_WIN, 4, cycles allowed for lcd_rdy to fall after lcd_enable rises.
TO_W, 20, done-watchdog width; timeout when the counter reaches all-ones (2^TO_W-1 cycles).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; one clock, reset is synchronous and active-low.
req  in  NREQ  per-requester request; held high until ack.
req_op  in  2*NREQ  per-requester op: 0 SEND_DATA, 1 CLEAR, 2/3 illegal.
req_data  in  8*NREQ  per-requester character byte (SEND_DATA only).
ack  out  NREQ  one-cycle completion pulse to the granted requester.
grant  out  NREQ  one-hot owner during a transaction, else 0.
boot_done  out  1  set once INIT completes; cleared only by reset.
err  out  1  sticky error (timeout or illegal op).
err_clr  in  1  clears err; loses to a same-cycle new error.
lcd_cmd  out  6  controller command code: 1 INIT, 3 SEND_DATA, 4 CLEAR.
lcd_enable  out  1  controller enable.
lcd_data  out  8  byte presented to the controller's external-data input.
lcd_rdy  in  1  controller ready (high when idle, low while executing).

Behaviour:
- Reset (rst_n=0 at clk edge): state BOOT; ack=0, grant=0, boot_done=0, err=0, lcd_cmd=0, lcd_enable=0, lcd_data=0, rr_ptr=0, counters=0.
- States: BOOT, ISSUE, WAIT_DONE, RELEASE, IDLE. All outputs are registered.
- BOOT: latch lcd_cmd=1 and owner=none. Go to ISSUE next cycle.
- ISSUE: lcd_enable=1; busy counter increments.
  - lcd_rdy=0 seen: go to WAIT_DONE, done counter cleared.
  - Busy counter reaches BUSY_WIN first: err=1, go to RELEASE.
- WAIT_DONE: lcd_enable stays 1.
  - lcd_rdy=1: go to RELEASE.
  - Done counter saturates at all-ones: err=1, go to RELEASE.
- RELEASE: exactly one cycle, lcd_enable=0.
  - Owner is a requester: ack[owner]=1, grant cleared.
  - Owner is boot, done path: boot_done=1.
  - Owner is boot, after a timeout: boot_done stays 0 and the next state is BOOT (INIT retried forever).
  - Otherwise go to IDLE.
- IDLE: lcd_enable=0. Arbitrate over req with round-robin priority starting at rr_ptr.
  - Winner w with op 0/1: grant[w]=1; latch lcd_cmd (3 or 4) and lcd_data=req_data[w]; rr_ptr=(w+1) mod NREQ; go to ISSUE the next cycle.
  - Illegal op (2/3) wins: no LCD access; err=1; go directly to RELEASE; ack pulses; rr_ptr advances.
  - No requests: stay in IDLE.
- Requesters are never arbitrated before boot_done=1.
- Latency, uncontended: req high in IDLE → lcd_enable high 1 cycle later.
- Ack timing: ack is high in the cycle after the clock edge that sampled lcd_rdy=1 in WAIT_DONE.
- Back-to-back: the requester drops req on the edge closing its ack cycle. The next IDLE arbitration sees the updated req, so lcd_enable is low for at least 2 cycles between transactions.
- req_op/req_data are sampled only at grant. Later changes are ignored until ack.
- A req deasserted mid-transaction does not abort it; ack still pulses.
- rr_ptr wraps from NREQ-1 to 0.
- Reset mid-transaction drops lcd_enable within 1 cycle and restarts boot INIT.
- Counters saturate and never wrap.

Decomposition:
- Shared package lcd_pkg holds:
  - controller command codes (INIT=1, CONFIG=2, SEND_DATA=3, CLEAR=4, OFF=5);
  - requester op encodings;
  - arbiter state encodings.
- One sub-module: lcd_rr_picker, a combinational round-robin one-hot picker (req, rr_ptr → grant, valid).

Test Plan:
- Release reset, model ready low 10 cycles from the enable edge → lcd_cmd=1 with enable; boot_done=1 the cycle after ready returns; no ack pulses.
- After boot, req[0]=1 op 0 data 8'h41 → lcd_cmd=3, lcd_data=8'h41, enable held until ready, ack[0] one pulse, enable low ≥2 cycles.
- req[0] and req[1] held continuously (ops 0 and 1) → grants alternate 0,1,0,1; lcd_cmd alternates 3,4; rr_ptr wraps.
- Model never drops ready → err=1 after BUSY_WIN=4 cycles, ack pulses; err_clr then clears err.
- Model stalls ready low past done timeout (TO_W=4 in this test) → err=1 after 15 cycles; during boot, INIT is retried and boot_done stays 0.
- req[1] with op 3 → ack[1] within 2 cycles, err=1, lcd_enable never rises; rst_n pulsed mid-CLEAR → outputs return to reset values and INIT is reissued.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command arbiter.
// Holds controller command codes, requester op encodings and arbiter FSM states.
package lcd_pkg;

  localparam logic [5:0] LCD_CMD_INIT      = 6'd1;
  localparam logic [5:0] LCD_CMD_CONFIG    = 6'd2;
  localparam logic [5:0] LCD_CMD_SEND_DATA = 6'd3;
  localparam logic [5:0] LCD_CMD_CLEAR     = 6'd4;
  localparam logic [5:0] LCD_CMD_OFF       = 6'd5;

  typedef enum logic [1:0] {
    OP_SEND_DATA = 2'd0,
    OP_CLEAR     = 2'd1,
    OP_ILLEGAL2  = 2'd2,
    OP_ILLEGAL3  = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_IDLE      = 3'd4
  } arb_state_e;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_SEND_DATA) || (op == OP_CLEAR);
  endfunction

  function automatic logic [5:0] op_to_cmd(input logic [1:0] op);
    return (op == OP_CLEAR) ? LCD_CMD_CLEAR : LCD_CMD_SEND_DATA;
  endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin picker: the first requester at or after ptr_i wins.
// Produces a one-hot grant and a valid flag.
module lcd_rr_picker #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic            valid_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters in priority order, wrapping the index below NREQ.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Shares one LCD 1602A controller between NREQ requesters: boots it with INIT,
// then grants it round-robin while owning the cmd/enable handshake and its watchdogs.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int BUSY_WIN = 4,
  parameter int TO_W     = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     grant,
  output logic                boot_done,
  output logic                err,
  input  logic                err_clr,
  output logic [5:0]          lcd_cmd,
  output logic                lcd_enable,
  output logic [7:0]          lcd_data,
  input  logic                lcd_rdy
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(BUSY_WIN + 1);
  localparam logic [BW-1:0]   BUSY_LAST = BW'(BUSY_WIN);
  localparam logic [TO_W-1:0] DONE_MAX  = '1;

  arb_state_e      state_q, state_d;
  logic [BW-1:0]   busy_q, busy_d;
  logic [TO_W-1:0] done_q, done_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   own_q, own_d;
  logic            own_boot_q, own_boot_d;
  logic            tout_q, tout_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            boot_done_q, boot_done_d;
  logic            err_q, err_d;
  logic            en_q, en_d;
  logic [5:0]      cmd_q, cmd_d;
  logic [7:0]      data_q, data_d;

  logic [NREQ-1:0] pick_grant;
  logic            pick_valid;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   rr_next;
  logic [1:0]      win_op;
  logic [7:0]      win_data;
  logic            go_rel;
  logic            tmo;
  logic            new_err;

  lcd_rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        win_idx = PW'(i);
      end
    end
  end

  assign win_op   = req_op[2*win_idx +: 2];
  assign win_data = req_data[8*win_idx +: 8];
  assign rr_next  = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;

  // Next-state logic; every exit into RELEASE funnels through go_rel so ack,
  // boot_done and the enable drop are decided in one place.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rr_d        = rr_q;
    own_d       = own_q;
    own_boot_d  = own_boot_q;
    tout_d      = tout_q;
    ack_d       = '0;
    grant_d     = grant_q;
    boot_done_d = boot_done_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    en_d        = en_q;
    go_rel      = 1'b0;
    tmo         = 1'b0;
    new_err     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        cmd_d      = LCD_CMD_INIT;
        data_d     = '0;
        own_boot_d = 1'b1;
        own_d      = '0;
        busy_d     = '0;
        en_d       = 1'b1;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!lcd_rdy) begin
          done_d  = '0;
          state_d = ST_WAIT_DONE;
        end else if (busy_q + 1'b1 == BUSY_LAST) begin
          busy_d = BUSY_LAST;
          go_rel = 1'b1;
          tmo    = 1'b1;
        end else begin
          busy_d = busy_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_rdy) begin
          go_rel = 1'b1;
        end else begin
          done_d = (done_q == DONE_MAX) ? done_q : done_q + 1'b1;
          if (done_d == DONE_MAX) begin
            go_rel = 1'b1;
            tmo    = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        en_d    = 1'b0;
        state_d = (own_boot_q && tout_q) ? ST_BOOT : ST_IDLE;
      end
      ST_IDLE: begin
        en_d = 1'b0;
        if (pick_valid) begin
          rr_d       = rr_next;
          own_boot_d = 1'b0;
          own_d      = win_idx;
          if (op_is_legal(win_op)) begin
            grant_d = pick_grant;
            cmd_d   = op_to_cmd(win_op);
            data_d  = win_data;
            busy_d  = '0;
            en_d    = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            new_err = 1'b1;
            go_rel  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (go_rel) begin
      state_d = ST_RELEASE;
      en_d    = 1'b0;
      grant_d = '0;
      tout_d  = tmo;
      if (tmo) begin
        new_err = 1'b1;
      end
      if (own_boot_d) begin
        if (!tmo) begin
          boot_done_d = 1'b1;
        end
      end else begin
        ack_d[own_d] = 1'b1;
      end
    end

    // A fresh error in the same cycle beats err_clr.
    err_d = (err_q & ~err_clr) | new_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      busy_q      <= '0;
      done_q      <= '0;
      rr_q        <= '0;
      own_q       <= '0;
      own_boot_q  <= 1'b0;
      tout_q      <= 1'b0;
      ack_q       <= '0;
      grant_q     <= '0;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rr_q        <= rr_d;
      own_q       <= own_d;
      own_boot_q  <= own_boot_d;
      tout_q      <= tout_d;
      ack_q       <= ack_d;
      grant_q     <= grant_d;
      boot_done_q <= boot_done_d;
      err_q       <= err_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      en_q        <= en_d;
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign boot_done  = boot_done_q;
  assign err        = err_q;
  assign lcd_cmd    = cmd_q;
  assign lcd_enable = en_q;
  assign lcd_data   = data_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Self-checking bench for lcd_cmd_arbiter: directed steps plus randomized requests,
// with expected timing derived from handshake arithmetic and a round-robin model.
module tb_lcd_cmd_arbiter;
  import lcd_pkg::*;

  localparam int NREQ     = 2;
  localparam int BUSY_WIN = 4;
  localparam int TO_W     = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   req_op;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     grant;
  logic                boot_done;
  logic                err;
  logic                err_clr;
  logic [5:0]          lcd_cmd;
  logic                lcd_enable;
  logic [7:0]          lcd_data;
  logic                lcd_rdy;

  int checks   = 0;
  int failures = 0;

  logic       reqM     [NREQ];
  logic [1:0] reqOpM   [NREQ];
  logic [7:0] reqDataM [NREQ];
  int         rrModel;
  logic       errModel;

  lcd_cmd_arbiter #(
    .NREQ     (NREQ),
    .BUSY_WIN (BUSY_WIN),
    .TO_W     (TO_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_op     (req_op),
    .req_data   (req_data),
    .ack        (ack),
    .grant      (grant),
    .boot_done  (boot_done),
    .err        (err),
    .err_clr    (err_clr),
    .lcd_cmd    (lcd_cmd),
    .lcd_enable (lcd_enable),
    .lcd_data   (lcd_data),
    .lcd_rdy    (lcd_rdy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      req[i]           = reqM[i];
      req_op[2*i +: 2] = reqOpM[i];
      req_data[8*i +: 8] = reqDataM[i];
    end
  endtask

  function automatic int rrWinner();
    for (int k = 0; k < NREQ; k++) begin
      if (reqM[(rrModel + k) % NREQ]) return (rrModel + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkReset();
    checkOutput("rst_ack",       32'(ack),        32'd0);
    checkOutput("rst_grant",     32'(grant),      32'd0);
    checkOutput("rst_boot_done", 32'(boot_done),  32'd0);
    checkOutput("rst_err",       32'(err),        32'd0);
    checkOutput("rst_cmd",       32'(lcd_cmd),    32'd0);
    checkOutput("rst_enable",    32'(lcd_enable), 32'd0);
    checkOutput("rst_data",      32'(lcd_data),   32'd0);
  endtask

  // One controller transaction. mode 0: ready falls d cycles after enable and stays
  // low L cycles; mode 1: ready never falls; mode 2: ready falls and never returns.
  task automatic serve(input bit isBoot, input int owner, input int mode, input int d,
                       input int L, input logic [5:0] expCmd, input logic [7:0] expData,
                       input int maxWait, output int waited);
    int r;
    bit enBad;
    bit ackBad;
    logic [NREQ-1:0] g;
    enBad  = 1'b0;
    ackBad = 1'b0;
    g      = '0;
    if (!isBoot) g[owner] = 1'b1;
    waited = 0;
    while (lcd_enable !== 1'b1 && waited < maxWait) begin
      step();
      waited++;
    end
    checkOutput("en_rise", 32'(lcd_enable), 32'd1);
    if (lcd_enable !== 1'b1) return;
    checkOutput("cmd", 32'(lcd_cmd), 32'(expCmd));
    checkOutput("data", 32'(lcd_data), 32'(expData));
    checkOutput("grant", 32'(grant), 32'(g));
    if (!isBoot) begin
      reqDataM[owner] = 8'($urandom);
      applyStimulus();
    end
    r = (mode == 0) ? d + L + 1 : (mode == 1) ? BUSY_WIN : d + (1 << TO_W);
    for (int k = 0; k < r; k++) begin
      if (lcd_enable !== 1'b1) enBad = 1'b1;
      if (ack !== '0) ackBad = 1'b1;
      if (mode == 0)      lcd_rdy = !(k >= d && k < d + L);
      else if (mode == 1) lcd_rdy = 1'b1;
      else                lcd_rdy = !(k >= d);
      step();
    end
    lcd_rdy = 1'b1;
    checkOutput("en_hold", 32'(enBad), 32'd0);
    checkOutput("ack_quiet", 32'(ackBad), 32'd0);
    checkOutput("en_drop", 32'(lcd_enable), 32'd0);
    checkOutput("ack_pulse", 32'(ack), 32'(g));
    checkOutput("boot_done", 32'(boot_done), isBoot ? 32'(mode == 0) : 32'd1);
    checkOutput("grant_clr", 32'(grant), 32'd0);
    checkOutput("err", 32'(err), 32'(errModel | (mode != 0)));
    checkOutput("data_hold", 32'(lcd_data), 32'(expData));
    if (mode != 0) errModel = 1'b1;
    step();
    checkOutput("ack_end", 32'(ack), 32'd0);
    checkOutput("en_gap", 32'(lcd_enable), 32'd0);
  endtask

  initial begin
    int waited;
    int w;
    rst_n   = 1'b0;
    lcd_rdy = 1'b1;
    err_clr = 1'b0;
    rrModel = 0;
    errModel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      reqM[i] = 1'b0;
      reqOpM[i] = OP_SEND_DATA;
      reqDataM[i] = 8'h00;
    end
    applyStimulus();
    repeat (3) step();
    checkReset();

    $display("[TB] boot with stalled controller, then retry");
    rst_n = 1'b1;
    serve(1'b1, 0, 2, 1, 0, LCD_CMD_INIT, 8'h00, 5, waited);
    serve(1'b1, 0, 0, 0, 10, LCD_CMD_INIT, 8'h00, 5, waited);
    err_clr = 1'b1;
    step();
    checkOutput("err_clr", 32'(err), 32'd0);
    err_clr = 1'b0;
    errModel = 1'b0;

    $display("[TB] single SEND_DATA");
    reqM[0] = 1'b1; reqOpM[0] = OP_SEND_DATA; reqDataM[0] = 8'h41;
    applyStimulus();
    serve(1'b0, 0, 0, 2, 3, LCD_CMD_SEND_DATA, 8'h41, 5, waited);
    checkOutput("latency", 32'(waited), 32'd1);
    reqM[0] = 1'b0;
    applyStimulus();
    rrModel = 1;

    $display("[TB] two requesters held continuously");
    reqM[0] = 1'b1; reqOpM[0] = OP_SEND_DATA; reqDataM[0] = 8'($urandom);
    reqM[1] = 1'b1; reqOpM[1] = OP_CLEAR;     reqDataM[1] = 8'($urandom);
    applyStimulus();
    for (int n = 0; n < 4; n++) begin
      w = rrWinner();
      serve(1'b0, w, 0, n % 4, 2 + n, op_to_cmd(reqOpM[w]), reqDataM[w], 5, waited);
      rrModel = (w + 1) % NREQ;
    end
    reqM[0] = 1'b0; reqM[1] = 1'b0;
    applyStimulus();

    $display("[TB] busy-window timeout");
    reqM[0] = 1'b1; reqOpM[0] = OP_SEND_DATA; reqDataM[0] = 8'h5A;
    applyStimulus();
    w = rrWinner();
    serve(1'b0, w, 1, 0, 0, LCD_CMD_SEND_DATA, 8'h5A, 5, waited);
    reqM[0] = 1'b0;
    applyStimulus();
    rrModel = (w + 1) % NREQ;

    $display("[TB] illegal op racing err_clr");
    reqM[1] = 1'b1; reqOpM[1] = OP_ILLEGAL3; reqDataM[1] = 8'hEE;
    err_clr = 1'b1;
    applyStimulus();
    checkOutput("ill_en_pre", 32'(lcd_enable), 32'd0);
    step();
    checkOutput("ill_ack", 32'(ack), 32'd2);
    checkOutput("ill_err_wins", 32'(err), 32'd1);
    checkOutput("ill_en", 32'(lcd_enable), 32'd0);
    reqM[1] = 1'b0;
    applyStimulus();
    rrModel = 0;
    step();
    checkOutput("ill_ack_end", 32'(ack), 32'd0);
    checkOutput("ill_err_clr", 32'(err), 32'd0);
    checkOutput("ill_en_post", 32'(lcd_enable), 32'd0);
    err_clr = 1'b0;
    errModel = 1'b0;
    reqM[0] = 1'b1; reqOpM[0] = OP_CLEAR;     reqDataM[0] = 8'h11;
    reqM[1] = 1'b1; reqOpM[1] = OP_SEND_DATA; reqDataM[1] = 8'h22;
    applyStimulus();
    w = rrWinner();
    serve(1'b0, w, 0, 1, 2, op_to_cmd(reqOpM[w]), reqDataM[w], 5, waited);
    rrModel = (w + 1) % NREQ;
    reqM[0] = 1'b0; reqM[1] = 1'b0;
    applyStimulus();

    $display("[TB] randomized request mix");
    for (int it = 0; it < 8; it++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!reqM[i] && $urandom_range(0, 1) == 1) begin
          reqM[i] = 1'b1;
          reqOpM[i] = 2'($urandom_range(0, 1));
          reqDataM[i] = 8'($urandom);
        end
        if (reqM[i]) any = 1'b1;
      end
      if (!any) begin
        reqM[it % NREQ] = 1'b1;
        reqOpM[it % NREQ] = 2'($urandom_range(0, 1));
        reqDataM[it % NREQ] = 8'($urandom);
      end
      applyStimulus();
      w = rrWinner();
      serve(1'b0, w, 0, int'($urandom_range(0, 3)), int'($urandom_range(1, 12)),
            op_to_cmd(reqOpM[w]), reqDataM[w], 5, waited);
      reqM[w] = 1'b0;
      applyStimulus();
      rrModel = (w + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) reqM[i] = 1'b0;
    applyStimulus();

    $display("[TB] reset during CLEAR");
    reqM[0] = 1'b1; reqOpM[0] = OP_CLEAR; reqDataM[0] = 8'h7F;
    applyStimulus();
    waited = 0;
    while (lcd_enable !== 1'b1 && waited < 5) begin
      step();
      waited++;
    end
    checkOutput("clr_cmd", 32'(lcd_cmd), 32'(LCD_CMD_CLEAR));
    lcd_rdy = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    reqM[0] = 1'b0;
    applyStimulus();
    lcd_rdy = 1'b1;
    step();
    checkReset();
    rst_n = 1'b1;
    rrModel = 0;
    errModel = 1'b0;
    serve(1'b1, 0, 0, 1, 3, LCD_CMD_INIT, 8'h00, 5, waited);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
